i2s_clock_rate_sequencer: RTL and testbench
===========================================

// Module: i2s_clock_rate_sequencer
// PURPOSE
//  Sequences sample-rate changes for the I2S master clock divider unit. Accepts a new
//  mclk/bclk/wclk divider set over a valid/ready handshake, validates it, and waits for a
//  wclk falling edge (frame boundary). It then pulses loadEn with the new dividers.
//  It reports lock once the new rate has run for SETTLE_FRAMES frames.
//  Sits between the CSR/bus slave and the clock divider unit, in the synthClk domain.
// PARAMETERS
//  SETTLE_FRAMES   2     wclk falling edges counted after load before locked=1 (1..15)
//  TIMEOUT_CYCLES  4096  synthClk cycles to wait for a frame edge (CFG_TIMEOUT_EN only)
// PORTS
//  synthClk     in   1   clock
//  synthReset   in   1   reset, asynchronous, active-high
//  cfgValid     in   1   new divider set offered
//  cfgReady     out  1   sequencer can accept a set (state IDLE or RUN)
//  cfgMclkDiv   in   10  requested mclk half-period divider
//  cfgBclkDiv   in   4   requested bclk divider
//  cfgWclkDiv   in   8   requested wclk divider
//  wclk         in   1   wclk from divider unit (synthClk-registered, no sync needed)
//  loadEn       out  1   one-cycle load strobe to divider unit
//  mclkDivider  out  10  active mclk divider (registered)
//  bclkDivider  out  4   active bclk divider (registered)
//  wclkDivider  out  8   active wclk divider (registered)
//  busy         out  1   change in progress (WAIT_EDGE, LOAD or SETTLE)
//  locked       out  1   new rate stable (state RUN)
//  cfgErr       out  1   one-cycle pulse: rejected set (any divider == 0)
// BEHAVIOUR
//  Reset values:
//  - dividers 72/4/64, loadEn=0, cfgErr=0, locked=0, busy=0, cfgReady=1, state IDLE.
//  - wclkPrev=0 and the frame/timeout counters clear.
//  - A reset mid-change drops the pending set.
//  Edge detect: fall = wclkPrev & !wclk. wclkPrev <= wclk every cycle.
//  Handshake:
//  - Transfer occurs when cfgValid & cfgReady; the set is captured into pending registers.
//  - cfgReady=0 in WAIT_EDGE/LOAD/SETTLE. cfgValid held there stays pending, not dropped.
//  - Any captured divider == 0: cfgErr=1 next cycle, no state change, dividers unchanged.
//  States:
//  - IDLE:      good transfer -> WAIT_EDGE.
//  - WAIT_EDGE: fall -> LOAD.
//  - LOAD:      loadEn=1 for exactly this cycle; divider outputs take pending values in
//               this same cycle and never change at any other time. Next state SETTLE,
//               frame counter cleared.
//  - SETTLE:    count fall; at count == SETTLE_FRAMES -> RUN.
//  - RUN:       locked=1. A good transfer drops locked the next cycle -> WAIT_EDGE.
//  Latency:
//  - loadEn rises 1 cycle after the cycle in which fall is seen in WAIT_EDGE.
//  - A fall in the same cycle as the transfer is ignored; the next fall is used.
//  Identical set accepted: full sequence still runs (realigns phase).
//  Frame counter is 4 bits and saturates; it never wraps.
// CONFIGURATION
//  CFG_TIMEOUT_EN defined:
//  - A 16-bit counter runs in WAIT_EDGE.
//  - After TIMEOUT_CYCLES cycles with no fall, go to LOAD anyway (stopped/stalled clocks).
//  - A fall in the same cycle as the timeout takes precedence; both lead to LOAD once.
//  CFG_TIMEOUT_EN undefined: no counter; WAIT_EDGE waits indefinitely.
// TESTING
//  1 Reset:
//    synthReset pulse -> dividers 72/4/64, loadEn=0, locked=0, cfgReady=1.
//  2 Normal change (SETTLE_FRAMES=2):
//    send 2/2/4 with wclk toggling every 16 cycles -> one loadEn pulse 1 cycle after the
//    first wclk fall; dividers 2/2/4 in the same cycle; locked=1 after 2 more falls.
//  3 Zero divider:
//    send 0/2/4 from RUN -> cfgErr pulse for 1 cycle; dividers, locked and state unchanged.
//  4 Back-pressure:
//    hold cfgValid with a second set during SETTLE -> cfgReady=0. Set accepted on entry to
//    RUN; second loadEn pulse at the next fall.
//  5 Reset mid-change:
//    assert synthReset in WAIT_EDGE -> no loadEn; reset values restored; pending set lost.
//  6 Timeout (CFG_TIMEOUT_EN, TIMEOUT_CYCLES=100):
//    wclk held 0 -> loadEn exactly 101 cycles after entering WAIT_EDGE.

Source files
------------

// File: rtl/i2s_clock_rate_sequencer.sv
// Sample-rate change sequencer for the I2S clock divider unit: validates a divider set,
// loads it on a wclk frame boundary and reports lock. Optional macro: CFG_TIMEOUT_EN.
module i2s_clock_rate_sequencer #(
   parameter int unsigned SETTLE_FRAMES = 2
`ifdef CFG_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic        synthClk,
   input  logic        synthReset,
   input  logic        cfgValid,
   output logic        cfgReady,
   input  logic [9:0]  cfgMclkDiv,
   input  logic [3:0]  cfgBclkDiv,
   input  logic [7:0]  cfgWclkDiv,
   input  logic        wclk,
   output logic        loadEn,
   output logic [9:0]  mclkDivider,
   output logic [3:0]  bclkDivider,
   output logic [7:0]  wclkDivider,
   output logic        busy,
   output logic        locked,
   output logic        cfgErr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_EDGE,
      S_LOAD,
      S_SETTLE,
      S_RUN
   } state_e;

   typedef struct packed {
      logic [9:0] mclk;
      logic [3:0] bclk;
      logic [7:0] wclk;
   } div_set_t;

   localparam div_set_t RESET_SET = '{mclk: 10'd72, bclk: 4'd4, wclk: 8'd64};

   state_e     state_q, state_d;
   div_set_t   pend_q, pend_d;
   div_set_t   active_q, active_d;
   logic       wclk_prev_q, wclk_prev_d;
   logic       load_en_q, load_en_d;
   logic       cfg_err_q, cfg_err_d;
   logic [3:0] frame_cnt_q, frame_cnt_d;

   div_set_t   req;
   logic       req_bad;
   logic       xfer;
   logic       fall;
   logic       go_load;
   logic [3:0] frame_cnt_inc;

   assign req           = '{mclk: cfgMclkDiv, bclk: cfgBclkDiv, wclk: cfgWclkDiv};
   assign req_bad       = (req.mclk == '0) | (req.bclk == '0) | (req.wclk == '0);
   assign cfgReady      = (state_q == S_IDLE) | (state_q == S_RUN);
   assign xfer          = cfgValid & cfgReady;
   assign fall          = wclk_prev_q & ~wclk;
   assign frame_cnt_inc = (frame_cnt_q == 4'hF) ? 4'hF : frame_cnt_q + 4'd1;

`ifdef CFG_TIMEOUT_EN
   // Stalled wclk must not block a rate change forever; a fall in the same cycle wins.
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        tmo_hit;

   assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
   assign go_load = fall | tmo_hit;

   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == S_WAIT_EDGE)
         tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
   end

   always_ff @(posedge synthClk or posedge synthReset) begin
      if (synthReset) tmo_cnt_q <= '0;
      else            tmo_cnt_q <= tmo_cnt_d;
   end
`else
   assign go_load = fall;
`endif

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      active_d    = active_q;
      wclk_prev_d = wclk;
      load_en_d   = 1'b0;
      cfg_err_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;
      if (xfer) begin
         pend_d    = req;
         cfg_err_d = req_bad;
      end
      unique case (state_q)
         S_IDLE, S_RUN: begin
            if (xfer && !req_bad) state_d = S_WAIT_EDGE;
         end
         S_WAIT_EDGE: begin
            // Dividers and strobe are registered so both appear in the LOAD cycle.
            if (go_load) begin
               state_d   = S_LOAD;
               active_d  = pend_q;
               load_en_d = 1'b1;
            end
         end
         S_LOAD: begin
            state_d     = S_SETTLE;
            frame_cnt_d = '0;
         end
         S_SETTLE: begin
            if (fall) begin
               frame_cnt_d = frame_cnt_inc;
               if (frame_cnt_inc == 4'(SETTLE_FRAMES)) state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge synthClk or posedge synthReset) begin
      if (synthReset) begin
         state_q     <= S_IDLE;
         pend_q      <= RESET_SET;
         active_q    <= RESET_SET;
         wclk_prev_q <= 1'b0;
         load_en_q   <= 1'b0;
         cfg_err_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         active_q    <= active_d;
         wclk_prev_q <= wclk_prev_d;
         load_en_q   <= load_en_d;
         cfg_err_q   <= cfg_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign loadEn      = load_en_q;
   assign mclkDivider = active_q.mclk;
   assign bclkDivider = active_q.bclk;
   assign wclkDivider = active_q.wclk;
   assign busy        = (state_q == S_WAIT_EDGE) | (state_q == S_LOAD) | (state_q == S_SETTLE);
   assign locked      = (state_q == S_RUN);
   assign cfgErr      = cfg_err_q;

endmodule

// File: tb/tb_i2s_clock_rate_sequencer.sv
// Randomized scoreboard bench for i2s_clock_rate_sequencer; expected events come from a
// cycle-level model built on a precomputed wclk schedule.
module tb_i2s_clock_rate_sequencer;

   localparam int N    = 12000;
   localparam int SF   = 2;
   localparam int REL0 = 3;
`ifdef CFG_TIMEOUT_EN
   localparam int TMO  = 100;
`endif

   logic       synthClk, synthReset, cfgValid, cfgReady, wclk;
   logic       loadEn, busy, locked, cfgErr;
   logic [9:0] cfgMclkDiv, mclkDivider;
   logic [3:0] cfgBclkDiv, bclkDivider;
   logic [7:0] cfgWclkDiv, wclkDivider;

`ifdef CFG_TIMEOUT_EN
   i2s_clock_rate_sequencer #(.SETTLE_FRAMES(SF), .TIMEOUT_CYCLES(TMO)) dut (
`else
   i2s_clock_rate_sequencer #(.SETTLE_FRAMES(SF)) dut (
`endif
      .synthClk(synthClk), .synthReset(synthReset), .cfgValid(cfgValid), .cfgReady(cfgReady),
      .cfgMclkDiv(cfgMclkDiv), .cfgBclkDiv(cfgBclkDiv), .cfgWclkDiv(cfgWclkDiv), .wclk(wclk),
      .loadEn(loadEn), .mclkDivider(mclkDivider), .bclkDivider(bclkDivider),
      .wclkDivider(wclkDivider), .busy(busy), .locked(locked), .cfgErr(cfgErr));

   typedef struct { int cyc; int m; int b; int w; } load_t;

   int    q_xfer[$];
   int    q_err[$];
   int    q_lock[$];
   load_t q_load[$];
   bit    wsched   [N];
   bit    exp_busy [N];
   bit    chk_rst  [N];
   int    cyc = 0;
   int    busy_until = 0;
   bit    done = 0;
   int    n_cmp = 0;
   int    n_bad = 0;

   initial begin
      synthClk = 1'b0;
      forever #5 synthClk = ~synthClk;
   end

   always @(posedge synthClk) cyc <= cyc + 1;

   initial begin
      wclk = 1'b0;
      forever begin
         @(posedge synthClk);
         #1;
         wclk = (cyc < N) ? wsched[cyc] : 1'b0;
      end
   end

   // Reference model: a fall is seen in cycle n when wclk went 1 -> 0 between n-1 and n.
   function automatic bit fall_at(input int n);
      return (n > 0) && (n < N) && wsched[n-1] && !wsched[n];
   endfunction

   function automatic int next_fall(input int from);
      for (int n = from; n < N; n++)
         if (fall_at(n)) return n;
      return -1;
   endfunction

   task automatic step();
      @(posedge synthClk);
      #1;
   endtask

   task automatic drive_idle();
      cfgValid   = 1'b0;
      cfgMclkDiv = 10'($urandom);
      cfgBclkDiv = 4'($urandom);
      cfgWclkDiv = 8'($urandom);
   endtask

   task automatic offer(input int m, input int b, input int w, input int gap, input bit rst_mid);
      int o, t, g, ld, lk, f, n;
      bit bad;
      for (int i = 0; i < gap; i++) begin
         drive_idle();
         step();
      end
      o   = cyc;
      t   = (o >= busy_until) ? o : busy_until;
      bad = (m == 0) || (b == 0) || (w == 0);
      n   = 0;
      q_xfer.push_back(t);
      if (bad) begin
         q_err.push_back(t + 1);
      end else if (!rst_mid) begin
         g = next_fall(t + 1);
`ifdef CFG_TIMEOUT_EN
         if (g < 0 || g > t + 1 + TMO) g = t + 1 + TMO;
`endif
         ld = g + 1;
         f  = ld + 1;
         for (int k = 0; k < SF; k++) begin
            n = next_fall(f);
            f = n + 1;
         end
         lk = n + 1;
         q_load.push_back('{cyc: ld, m: m, b: b, w: w});
         q_lock.push_back(lk);
         for (int c = t + 1; c < lk; c++) exp_busy[c] = 1'b1;
         busy_until = lk;
      end
      cfgValid   = 1'b1;
      cfgMclkDiv = 10'(m);
      cfgBclkDiv = 4'(b);
      cfgWclkDiv = 8'(w);
      while (cyc < t) step();
      step();
      drive_idle();
      if (rst_mid) begin
         synthReset = 1'b1;
         repeat (3) step();
         synthReset = 1'b0;
         chk_rst[cyc] = 1'b1;
         busy_until = 0;
      end
   endtask

   // Driver: builds the wclk schedule, then issues divider sets.
   initial begin
      int p, h, len, m, b, w, pm, pb, pw, gap;
      bit last_stop, lvl, rm;
      synthReset = 1'b1;
      drive_idle();
      for (p = 0; p < 20; p++) wsched[p] = 1'b0;
      last_stop = 1'b1;
      while (p < N) begin
         if (!last_stop && $urandom_range(0, 4) == 0) begin
            len = $urandom_range(150, 260);
            for (int i = 0; i < len && p < N; i++) begin wsched[p] = 1'b0; p++; end
            last_stop = 1'b1;
         end else begin
            h   = $urandom_range(3, 20);
            len = $urandom_range(4, 12);
            lvl = 1'b1;
            for (int i = 0; i < len; i++) begin
               for (int j = 0; j < h && p < N; j++) begin wsched[p] = lvl; p++; end
               lvl = ~lvl;
            end
            last_stop = 1'b0;
         end
      end
      repeat (REL0) step();
      synthReset = 1'b0;
      chk_rst[cyc] = 1'b1;
      offer(2, 2, 4, 2, 1'b0);
      pm = 2; pb = 2; pw = 4;
      offer(300, 7, 100, 0, 1'b0);
      pm = 300; pb = 7; pw = 100;
      for (int i = 0; i < 30 && cyc < N - 2000; i++) begin
         m = $urandom_range(1, 1023);
         b = $urandom_range(1, 15);
         w = $urandom_range(1, 255);
         if ($urandom_range(0, 5) == 0) begin m = pm; b = pb; w = pw; end
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 2))
               0:       m = 0;
               1:       b = 0;
               default: w = 0;
            endcase
         end
         gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 60);
         rm  = (i == 10);
         if (rm) begin
            m = $urandom_range(1, 1023); b = 9; w = 33;
            gap = (busy_until > cyc) ? busy_until - cyc + 3 : 3;
         end
         offer(m, b, w, gap, rm);
         pm = m; pb = b; pw = w;
      end
      while (cyc < busy_until + 4) step();
      repeat (4) step();
      done = 1'b1;
   end

   task automatic cmp(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Monitor: pops and checks whenever the DUT presents an event.
   initial begin
      bit         lprev;
      logic [9:0] prev_m;
      logic [3:0] prev_b;
      logic [7:0] prev_w;
      load_t      e;
      int         x;
      lprev = 1'b0;
      prev_m = '0; prev_b = '0; prev_w = '0;
      forever begin
         @(negedge synthClk);
         if (done) begin
            cmp("xfer_left", q_xfer.size(), 0);
            cmp("load_left", q_load.size(), 0);
            cmp("err_left", q_err.size(), 0);
            cmp("lock_left", q_lock.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end else if (cyc >= N - 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL watchdog: reached cycle %0d without completion, required < %0d", cyc, N - 1);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end else if (synthReset || cyc < REL0) begin
            lprev = 1'b0;
            prev_m = mclkDivider; prev_b = bclkDivider; prev_w = wclkDivider;
         end else begin
            if (chk_rst[cyc]) begin
               cmp("rst_mclk", int'(mclkDivider), 72);
               cmp("rst_bclk", int'(bclkDivider), 4);
               cmp("rst_wclk", int'(wclkDivider), 64);
               cmp("rst_loadEn", int'(loadEn), 0);
               cmp("rst_locked", int'(locked), 0);
               cmp("rst_cfgReady", int'(cfgReady), 1);
               cmp("rst_cfgErr", int'(cfgErr), 0);
            end
            cmp("busy", int'(busy), int'(exp_busy[cyc]));
            cmp("cfgReady", int'(cfgReady), int'(!exp_busy[cyc]));
            if (cfgValid && cfgReady) begin
               x = (q_xfer.size() > 0) ? q_xfer.pop_front() : -1;
               cmp("xfer_cycle", cyc, x);
            end
            if (loadEn) begin
               e = '{cyc: -1, m: -1, b: -1, w: -1};
               if (q_load.size() > 0) e = q_load.pop_front();
               cmp("load_cycle", cyc, e.cyc);
               cmp("load_mclk", int'(mclkDivider), e.m);
               cmp("load_bclk", int'(bclkDivider), e.b);
               cmp("load_wclk", int'(wclkDivider), e.w);
            end
            if (cfgErr) begin
               x = (q_err.size() > 0) ? q_err.pop_front() : -1;
               cmp("err_cycle", cyc, x);
            end
            if (locked && !lprev) begin
               x = (q_lock.size() > 0) ? q_lock.pop_front() : -1;
               cmp("lock_cycle", cyc, x);
            end
            if (mclkDivider != prev_m || bclkDivider != prev_b || wclkDivider != prev_w)
               cmp("div_change_without_load", int'(loadEn), 1);
            lprev = locked;
            prev_m = mclkDivider; prev_b = bclkDivider; prev_w = wclkDivider;
         end
      end
   end

endmodule
